multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL have port: data_operandA  input  32  signed two's-complement multiplicand/dividend.
REQ-004 SHALL have port: data_operandB  input  32  signed two's-complement multiplier/divisor.
REQ-005 SHALL have port: ctrl_MULT  input  1  one-cycle start pulse for multiply.
REQ-006 SHALL have port: ctrl_DIV  input  1  one-cycle start pulse for divide.
REQ-007 SHALL have port: data_result  output  32  product (low 32 bits) or quotient.
REQ-008 SHALL have port: data_exception  output  1  overflow or divide-by-zero flag for the current result.
REQ-009 SHALL have port: data_resultRDY  output  1  result-valid strobe, exactly one cycle wide.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-011 SHALL sample ctrl_MULT/ctrl_DIV at every rising edge in every state; a start latches both operands and enters MUL or DIV with iteration counter = 0.
REQ-012 SHALL give ctrl_MULT priority when both starts are high in the same cycle.
REQ-013 SHALL abort any operation in progress (MUL, DIV or DONE) on a new start and restart with newly latched operands; the aborted result is never flagged ready.
REQ-014 SHALL ignore operand changes after the start edge.
REQ-015 SHALL use N iteration edges per operation: multiply N = NMUL (see Configuration); divide N = 32.
REQ-016 SHALL, for a start sampled at edge t, raise data_resultRDY after edge t+N and drop it after edge t+N+1 (state DONE, then IDLE).
REQ-017 SHALL compute multiply as a signed Booth product into a 64-bit accumulator; data_result = product[31:0].
REQ-018 SHALL set data_exception on multiply when product[63:31] is neither all-zeros nor all-ones.
REQ-019 SHALL compute divide as non-restoring/restoring division on operand magnitudes, quotient truncated toward zero and negated when operand signs differ; remainder is discarded.
REQ-020 SHALL, on divide with data_operandB = 0, run full 32-cycle latency, then return data_result = 0 and data_exception = 1.
REQ-021 SHALL, on 0x80000000 / 0xFFFFFFFF, return data_result = 0x80000000 and data_exception = 1.
REQ-022 SHALL hold data_result and data_exception stable from the DONE cycle until the next start.
REQ-023 SHALL keep data_exception = 0 for every result not covered by REQ-018, REQ-020 or REQ-021.

Reset
REQ-024 SHALL, on reset assertion (including mid-operation), immediately force state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0.
REQ-025 SHALL ignore ctrl_MULT/ctrl_DIV while reset is high; first start is accepted at the first rising edge after deassertion.

Configuration
REQ-026 SHALL, with MULTDIV_BOOTH4_EN defined, use radix-4 modified Booth multiply with NMUL = 16.
REQ-027 SHALL, without MULTDIV_BOOTH4_EN, use radix-2 Booth multiply with NMUL = 32.
REQ-028 SHALL produce bit-identical data_result/data_exception in both configurations; only latency differs.

Structure
REQ-029 SHALL place the FSM state enum, NMUL, NDIV = 32 and the operand width (32) in shared package multdiv_pkg.
REQ-030 SHALL implement one divide iteration (shift, trial subtract, quotient bit) as combinational sub-module multdiv_div_step.

Verification
REQ-031 SHALL test: ctrl_MULT with A=7, B=-3 -> data_result 0xFFFFFFEB (-21), exception 0, RDY after edge t+NMUL.
REQ-032 SHALL test: ctrl_MULT with A=0x7FFFFFFF, B=2 -> data_result 0xFFFFFFFE, exception 1.
REQ-033 SHALL test: ctrl_DIV with A=-100, B=7 -> data_result 0xFFFFFFF2 (-14), exception 0, RDY after edge t+32.
REQ-034 SHALL test: ctrl_DIV with A=5, B=0 -> data_result 0, exception 1 at t+32; ctrl_DIV with 0x80000000/-1 -> 0x80000000, exception 1.
REQ-035 SHALL test: ctrl_DIV 100/9 started, ctrl_MULT 6*6 issued at t+10 -> single RDY pulse at (t+10)+NMUL with result 36; no RDY at t+32.
REQ-036 SHALL test: reset asserted at t+5 of a multiply -> all outputs 0 immediately, no RDY pulse afterwards until a new start.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the multiply/divide unit.
//   WIDTH  operand/result width
//   NMUL   multiply iterations (16 with MULTDIV_BOOTH4_EN defined, else 32)
//   NDIV   divide iterations
//   state_e  controller states
package multdiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NDIV  = 32;
`ifdef MULTDIV_BOOTH4_EN
    localparam int unsigned NMUL  = 16;
`else
    localparam int unsigned NMUL  = 32;
`endif
    localparam int unsigned CNTW  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/multdiv_div_step.sv
// multdiv_div_step: one combinational restoring-division iteration on
// unsigned magnitudes.
//   rem_i     partial remainder (always < divisor_i for a nonzero divisor)
//   quo_i     dividend bits still to shift in (MSB first); quotient bits
//             enter at the LSB
//   divisor_i divisor magnitude
//   rem_o     updated partial remainder
//   quo_o     shifted dividend/quotient register
module multdiv_div_step
    import multdiv_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           qbit;

    // 33-bit trial subtract: bit WIDTH set means the trial went negative.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign qbit    = ~diff[WIDTH];
    assign rem_o   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], qbit};

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply (Booth) and divide.
//   clock           rising-edge clock
//   reset           asynchronous active-high reset
//   data_operandA   multiplicand / dividend (signed)
//   data_operandB   multiplier / divisor (signed)
//   ctrl_MULT       start multiply (priority over ctrl_DIV)
//   ctrl_DIV        start divide
//   data_result     product[31:0] or quotient, held until next start
//   data_exception  multiply overflow, divide-by-zero or MIN/-1
//   data_resultRDY  one-cycle result strobe
// Define MULTDIV_BOOTH4_EN for radix-4 Booth (16-cycle multiply);
// default is radix-2 Booth (32-cycle multiply).
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_e             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               sdiff_q, sdiff_d;
    logic               dz_q, dz_d;
    logic               dovf_q, dovf_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;

    logic [2*WIDTH-1:0] booth_add;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    multdiv_div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            sdiff_q   <= 1'b0;
            dz_q      <= 1'b0;
            dovf_q    <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            sdiff_q   <= sdiff_d;
            dz_q      <= dz_d;
            dovf_q    <= dovf_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        sdiff_d   = sdiff_q;
        dz_d      = dz_q;
        dovf_d    = dovf_q;
        result_d  = result_q;
        exc_d     = exc_q;
        booth_add = '0;
        prod_next = prod_q;

        case (state_q)
            MUL: begin
                // Booth digit times the multiplicand already scaled by its
                // weight; mplier_q[0] holds the previously consumed bit.
`ifdef MULTDIV_BOOTH4_EN
                case (mplier_q[2:0])
                    3'b001, 3'b010: booth_add = mcand_q;
                    3'b011:         booth_add = mcand_q << 1;
                    3'b100:         booth_add = -(mcand_q << 1);
                    3'b101, 3'b110: booth_add = -mcand_q;
                    default:        booth_add = '0;
                endcase
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
`else
                case (mplier_q[1:0])
                    2'b01:   booth_add = mcand_q;
                    2'b10:   booth_add = -mcand_q;
                    default: booth_add = '0;
                endcase
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
`endif
                prod_next = prod_q + booth_add;
                prod_d    = prod_next;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNTW'(NMUL - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = prod_next[WIDTH-1:0];
                    exc_d    = !((&prod_next[2*WIDTH-1:WIDTH-1]) ||
                                 (~|prod_next[2*WIDTH-1:WIDTH-1]));
                end
            end
            DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(NDIV - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    result_d = dz_q ? '0 : (sdiff_q ? -step_quo : step_quo);
                    exc_d    = dz_q | dovf_q;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase

        // A start in any state aborts the current operation.
        if (ctrl_MULT) begin
            state_d  = MUL;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
            mplier_d = {data_operandB, 1'b0};
            prod_d   = '0;
        end else if (ctrl_DIV) begin
            state_d   = DIV;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_mag;
            divisor_d = b_mag;
            sdiff_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d      = (data_operandB == '0);
            dovf_d    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (data_operandB == '1);
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        bit          exc;
        int          cyc;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[18];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_count = 0;
    bit   prev_rdy = 1'b0;
    sb_t  mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every RDY pulse must match the oldest expected entry.
    always begin
        @(posedge clock);
        cyc++;
        #1;
        if (data_resultRDY) begin
            rdy_count++;
            checks++;
            if (prev_rdy) begin
                failures++;
                $display("FAIL rdy_width: got RDY high two cycles, expected one (cycle %0d)", cyc);
            end
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_rdy: got RDY, expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rdy_cycle", 32'(cyc), 32'(mon_e.cyc));
                chk("result", data_result, mon_e.res);
                chk("exception", {31'b0, data_exception}, {31'b0, mon_e.exc});
            end
        end
        prev_rdy = data_resultRDY;
    end

    task automatic start_op(input bit mul, input bit dv, input logic [31:0] a,
                            input logic [31:0] b, input bit push,
                            input logic [31:0] er, input bit ee);
        int n;
        n = mul ? int'(NMUL) : int'(NDIV);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = dv;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        if (push) sb.push_back('{res: er, exc: ee, cyc: cyc + n});
    endtask

    task automatic drain(input logic [31:0] er, input bit ee);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 45) begin
            @(posedge clock);
            #2;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rdy_timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clock);
        #2;
        chk("hold_result", data_result, er);
        chk("hold_exception", {31'b0, data_exception}, {31'b0, ee});
        chk("rdy_low", {31'b0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        int rc;
        vecs[0]  = '{1, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0};
        vecs[1]  = '{1, 32'h7FFFFFFF,   32'd2,        32'hFFFFFFFE, 1};
        vecs[2]  = '{1, 32'd6,          32'd6,        32'd36,       0};
        vecs[3]  = '{1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        0};
        vecs[4]  = '{1, 32'h80000000,   32'd1,        32'h80000000, 0};
        vecs[5]  = '{1, 32'h80000000,   32'h80000000, 32'd0,        1};
        vecs[6]  = '{1, 32'h00010000,   32'h00008000, 32'h80000000, 1};
        vecs[7]  = '{1, 32'h00010000,   32'hFFFF8000, 32'h80000000, 0};
        vecs[8]  = '{0, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 0};
        vecs[9]  = '{0, 32'd5,          32'd0,        32'd0,        1};
        vecs[10] = '{0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{0, 32'd100,        32'd9,        32'd11,       0};
        vecs[12] = '{0, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 0};
        vecs[13] = '{0, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        0};
        vecs[14] = '{0, 32'h80000000,   32'd2,        32'hC0000000, 0};
        vecs[15] = '{0, 32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 0};
        vecs[16] = '{0, 32'd3,          32'd5,        32'd0,        0};
        vecs[17] = '{0, 32'd0,          32'hFFFFFFFB, 32'd0,        0};

        // Reset with a start held high: it must be ignored.
        reset = 1'b1;
        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd6;
        data_operandB = 32'd6;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exception", {31'b0, data_exception}, 32'd0);
        chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        repeat (40) @(posedge clock);
        #2;
        chk("no_rdy_after_reset", 32'(rdy_count), 32'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].is_mul, !vecs[i].is_mul, vecs[i].a, vecs[i].b, 1'b1,
                     vecs[i].res, vecs[i].exc);
            drain(vecs[i].res, vecs[i].exc);
        end

        // Both starts together: multiply wins (6*6, not 6/6).
        start_op(1'b1, 1'b1, 32'd6, 32'd6, 1'b1, 32'd36, 1'b0);
        drain(32'd36, 1'b0);

        // Divide 100/9 aborted by multiply 6*6 ten edges later.
        start_op(1'b0, 1'b1, 32'd100, 32'd9, 1'b0, 32'd0, 1'b0);
        rc = rdy_count;
        repeat (9) @(posedge clock);
        start_op(1'b1, 1'b0, 32'd6, 32'd6, 1'b1, 32'd36, 1'b0);
        drain(32'd36, 1'b0);
        repeat (20) @(posedge clock);
        #2;
        chk("abort_single_rdy", 32'(rdy_count - rc), 32'd1);

        // Reset five edges into a multiply.
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, 32'd0, 1'b0);
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("midreset_result", data_result, 32'd0);
        chk("midreset_exception", {31'b0, data_exception}, 32'd0);
        chk("midreset_rdy", {31'b0, data_resultRDY}, 32'd0);
        rc = rdy_count;
        @(negedge clock);
        reset = 1'b0;
        repeat (NMUL + 8) @(posedge clock);
        #2;
        chk("midreset_no_rdy", 32'(rdy_count - rc), 32'd0);
        chk("midreset_hold", data_result, 32'd0);

        // Back to normal operation after reset.
        start_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 1'b0);
        drain(32'hFFFFFFF2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
